corner_coord_sink: RTL and testbench

Receiving end of the detector pixel stream. Consumes the per-pixel corner decision emitted by `harrisDetector` in raster order and tracks the (x, y) position of each qualified pixel. Every flagged pixel becomes a coordinate record in an internal FIFO, drained by a downstream consumer over a valid/ready handshake. Also reports frame boundaries, per-frame corner counts and overflow drops, so benches and hardware can read back detection results instead of waveform-probing the detector.

---
 rtl/corner_coord_sink.sv | 147 ++++++++++++++
 tb/tb_corner_coord_sink.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/corner_coord_sink.sv
// Sink for the corner detector pixel stream: tracks raster position, queues the
// (x, y) of every flagged pixel and reports per-frame counts and overflow drops.
module corner_coord_sink #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic                     pix_corner,
  output logic                     coord_valid,
  input  logic                     coord_ready,
  output logic [X_W-1:0]           coord_x,
  output logic [Y_W-1:0]           coord_y,
  output logic                     frame_done,
  output logic [15:0]              frame_corners,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = X_W + Y_W;
  localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      sat_inc = v + 16'd1;
    end else begin
      sat_inc = v;
    end
  endfunction

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      drop_q, drop_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      frame_corners_q, frame_corners_d;
  logic             frame_done_q, frame_done_d;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic push_s, pop_s, full_s, push_ok_s, last_pix_s;

  always_comb begin
    push_s     = pix_valid & pix_corner;
    pop_s      = coord_valid & coord_ready;
    full_s     = (level_q == LVL_FULL);
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    push_ok_s  = push_s & (~full_s | pop_s);
    last_pix_s = pix_valid & (x_q == X_LAST) & (y_q == Y_LAST);
  end

  always_comb begin
    x_d             = x_q;
    y_d             = y_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    drop_d          = sat_inc(drop_q, push_s & full_s & ~pop_s);
    frame_done_d    = last_pix_s;
    frame_cnt_d     = frame_cnt_q;
    frame_corners_d = frame_corners_q;

    if (pix_valid) begin
      if (x_q == X_LAST) begin
        x_d = {X_W{1'b0}};
        y_d = (y_q == Y_LAST) ? {Y_W{1'b0}} : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end else begin
      x_d = x_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Dropped records still count toward the frame total.
    if (last_pix_s) begin
      frame_corners_d = sat_inc(frame_cnt_q, push_s);
      frame_cnt_d     = 16'd0;
    end else begin
      frame_cnt_d     = sat_inc(frame_cnt_q, push_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q             <= {X_W{1'b0}};
      y_q             <= {Y_W{1'b0}};
      wr_ptr_q        <= {PTR_W{1'b0}};
      rd_ptr_q        <= {PTR_W{1'b0}};
      level_q         <= {LVL_W{1'b0}};
      drop_q          <= 16'd0;
      frame_cnt_q     <= 16'd0;
      frame_corners_q <= 16'd0;
      frame_done_q    <= 1'b0;
    end else begin
      x_q             <= x_d;
      y_q             <= y_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      drop_q          <= drop_d;
      frame_cnt_q     <= frame_cnt_d;
      frame_corners_q <= frame_corners_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Record storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= {y_q, x_q};
    end
  end

  assign coord_valid   = (level_q != {LVL_W{1'b0}});
  assign coord_x       = coord_valid ? mem_q[rd_ptr_q][X_W-1:0] : {X_W{1'b0}};
  assign coord_y       = coord_valid ? mem_q[rd_ptr_q][REC_W-1:X_W] : {Y_W{1'b0}};
  assign frame_done    = frame_done_q;
  assign frame_corners = frame_corners_q;
  assign drop_count    = drop_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_corner_coord_sink.sv
// Scoreboard bench for corner_coord_sink: expected records are queued as pixels
// are issued and a negedge monitor checks every accepted head against the queue.
module tb_corner_coord_sink;
  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset, pix_valid, pix_corner, coord_ready;
  logic        coord_valid, frame_done;
  logic [7:0]  coord_x, coord_y;
  logic [15:0] frame_corners, drop_count;
  logic [2:0]  fifo_level;

  int          total = 0;
  int          bad = 0;
  int          mx = 0;
  int          my = 0;
  int          mlevel = 0;
  logic [15:0] exp_q[$];
  logic [15:0] head_e;

  always #5 clk = ~clk;

  corner_coord_sink #(.IMG_W(W), .IMG_H(H), .X_W(8), .Y_W(8), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_corner(pix_corner),
    .coord_valid(coord_valid), .coord_ready(coord_ready), .coord_x(coord_x),
    .coord_y(coord_y), .frame_done(frame_done), .frame_corners(frame_corners),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: v/c held for one edge; model decides queue/drop and position.
  task automatic pix(input logic v, input logic c);
    logic pop, push_ok, fd_exp;
    pix_valid  = v;
    pix_corner = c;
    pop     = (mlevel > 0) && coord_ready;
    push_ok = v && c && ((mlevel < D) || pop);
    fd_exp  = v && (mx == W - 1) && (my == H - 1);
    if (push_ok) exp_q.push_back({8'(my), 8'(mx)});
    mlevel = mlevel + (push_ok ? 1 : 0) - (pop ? 1 : 0);
    if (v) begin
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(posedge clk);
    #1;
    chk("frame_done", int'(frame_done), int'(fd_exp));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    mx = 0;
    my = 0;
    mlevel = 0;
    exp_q.delete();
    for (int i = 0; i < cycles; i++) begin
      pix_valid  = 1'($urandom_range(0, 1));
      pix_corner = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rst_valid", int'(coord_valid), 0);
    chk("rst_x", int'(coord_x), 0);
    chk("rst_y", int'(coord_y), 0);
    chk("rst_fdone", int'(frame_done), 0);
    chk("rst_fcorners", int'(frame_corners), 0);
    chk("rst_drops", int'(drop_count), 0);
    chk("rst_level", int'(fifo_level), 0);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && coord_valid === 1'b1 && coord_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got x=%0d y=%0d expected no record", coord_x, coord_y);
      end else begin
        head_e = exp_q.pop_front();
        if ({coord_y, coord_x} !== head_e) begin
          bad++;
          $display("FAIL sb_record: got x=%0d y=%0d expected x=%0d y=%0d",
                   coord_x, coord_y, head_e[7:0], head_e[15:8]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    coord_ready = 1'b0;
    pix_valid = 1'b0;
    pix_corner = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Frame 1: no corners.
    for (int i = 0; i < W * H; i++) pix(1'b1, 1'b0);
    chk("f1_corners", int'(frame_corners), 0);

    // Frame 2: single corner at index 10 -> (2,1), one-cycle latency.
    coord_ready = 1'b1;
    for (int i = 0; i < 10; i++) pix(1'b1, 1'b0);
    pix(1'b1, 1'b1);
    chk("lat_valid", int'(coord_valid), 1);
    chk("lat_x", int'(coord_x), 2);
    chk("lat_y", int'(coord_y), 1);
    pix(1'b1, 1'b0);
    chk("lat_valid_low", int'(coord_valid), 0);
    for (int i = 12; i < W * H; i++) pix(1'b1, 1'b0);
    chk("f2_corners", int'(frame_corners), 1);

    // Frame 3: ordering under backpressure (0,0),(7,0),(3,2).
    coord_ready = 1'b0;
    for (int i = 0; i < 20; i++) pix(1'b1, (i == 0) || (i == 7) || (i == 19));
    chk("ord_level", int'(fifo_level), 3);
    coord_ready = 1'b1;
    for (int i = 20; i < W * H; i++) pix(1'b1, 1'b0);
    chk("ord_drained", int'(fifo_level), 0);
    chk("f3_corners", int'(frame_corners), 3);

    // Frame 4: overflow, 6 corners from (0,1) into a 4-deep FIFO.
    coord_ready = 1'b0;
    for (int i = 0; i < 14; i++) pix(1'b1, (i >= 8));
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_drops", int'(drop_count), 2);
    chk("ovf_head_x", int'(coord_x), 0);
    chk("ovf_head_y", int'(coord_y), 1);
    for (int i = 14; i < W * H; i++) pix(1'b1, 1'b0);
    chk("f4_corners", int'(frame_corners), 6);
    coord_ready = 1'b1;
    for (int i = 0; i < 5; i++) pix(1'b0, 1'b0);
    chk("ovf_drained", int'(fifo_level), 0);

    // Frame 5: fill to 4, then push while popping.
    coord_ready = 1'b0;
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1);
    chk("full_level", int'(fifo_level), 4);
    coord_ready = 1'b1;
    pix(1'b1, 1'b1);
    chk("fullpop_level", int'(fifo_level), 4);
    chk("fullpop_drops", int'(drop_count), 2);
    for (int i = 5; i < W * H; i++) pix(1'b1, 1'b0);
    chk("f5_corners", int'(frame_corners), 5);
    chk("full_drained", int'(fifo_level), 0);

    // Frame 6: gaps, then reset mid-frame with two records queued.
    coord_ready = 1'b0;
    pix(1'b1, 1'b0);
    pix(1'b0, 1'b1);
    pix(1'b1, 1'b1);
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    for (int i = 2; i < 12; i++) pix(1'b1, 1'b0);
    pix(1'b1, 1'b1);
    chk("gap_level", int'(fifo_level), 2);
    chk("gap_head_x", int'(coord_x), 1);
    chk("gap_head_y", int'(coord_y), 0);
    do_reset(1);
    coord_ready = 1'b1;
    pix(1'b1, 1'b1);
    chk("post_rst_valid", int'(coord_valid), 1);
    chk("post_rst_x", int'(coord_x), 0);
    chk("post_rst_y", int'(coord_y), 0);
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
